wb_write_buffer: RTL and testbench

- Writer-side front end of the 32x32 register file write port.
- Queues results from long-latency producers (mul/div, cache-miss loads) and drains them into the single RF write port (RFWr/Addr3/WD) only in cycles when the main pipeline is not writing back.
- Gives the decode stage forwarding lookups so reads of a still-queued destination return the pending value.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/wbb_fwd_match.sv | 35 +++
 rtl/wb_write_buffer.sv | 128 ++++++++++++
 tb/tb_wb_write_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write buffer: widths,
// the queued entry layout and the hard-wired zero register.
package cpu_pkg;

   localparam int CPU_AW = 5;
   localparam int CPU_DW = 32;

   typedef struct packed {
      logic [CPU_AW-1:0] addr;
      logic [CPU_DW-1:0] data;
   } wbb_entry_t;

   localparam logic [CPU_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wbb_fwd_match.sv
// Youngest-first forwarding match over the write-buffer entries.
// Scans from head (oldest) toward tail; the last occupied match wins,
// which is the entry nearest the tail.
module wbb_fwd_match
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH) + 1
) (
   input  wbb_entry_t         ent_i [DEPTH],
   input  logic [DEPTH-1:0]   vld_i,
   input  logic [PW-1:0]      head_i,
   input  logic [CPU_AW-1:0]  lk_addr_i,
   output logic               hit_o,
   output logic [CPU_DW-1:0]  data_o
);

   localparam int IW = $clog2(DEPTH);

   // Priority match: oldest to youngest, later hits override earlier ones
   always_comb begin
      logic [IW-1:0] idx;
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i[IW-1:0] + IW'(k);
         if (vld_i[idx] && (ent_i[idx].addr == lk_addr_i) && (lk_addr_i != REG_ZERO)) begin
            hit_o  = 1'b1;
            data_o = ent_i[idx].data;
         end
      end
   end

endmodule

// File: rtl/wb_write_buffer.sv
// Register-file write buffer: queues long-latency results and drains them
// into the RF write port in cycles the main pipeline leaves it free, with
// two forwarding lookup ports for decode.
// Optional feature macro: WB_WRITE_BUFFER_COALESCE_EN -- an enqueue that
// targets the youngest entry's register overwrites that entry in place.
module wb_write_buffer
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = CPU_AW,
   parameter int DW    = CPU_DW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   input  logic                     rf_busy,
   output logic                     rf_we,
   output logic [AW-1:0]            rf_addr,
   output logic [DW-1:0]            rf_wd,
   input  logic [AW-1:0]            lk_addr1,
   input  logic [AW-1:0]            lk_addr2,
   output logic                     fwd_hit1,
   output logic                     fwd_hit2,
   output logic [DW-1:0]            fwd_data1,
   output logic [DW-1:0]            fwd_data2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   wbb_entry_t       ent_q [DEPTH];

   logic [PW-1:0]    occ;
   logic [IW-1:0]    head_idx, tail_idx, yng_idx;
   logic             pop, coal, accept, alloc, merge;

   assign occ      = tail_q - head_q;
   assign count    = occ;
   assign empty    = (occ == '0);
   assign full     = (occ == PW'(DEPTH));
   assign head_idx = head_q[IW-1:0];
   assign tail_idx = tail_q[IW-1:0];
   assign yng_idx  = tail_idx - IW'(1);

   // Drain side: the RF takes the head whenever the pipeline leaves the port idle
   assign pop     = !empty && !rf_busy;
   assign rf_we   = pop;
   assign rf_addr = empty ? '0 : ent_q[head_idx].addr;
   assign rf_wd   = empty ? '0 : ent_q[head_idx].data;

`ifdef WB_WRITE_BUFFER_COALESCE_EN
   // Merge into the youngest entry unless that entry is the head leaving now
   assign coal = !empty && (ent_q[yng_idx].addr == in_addr) && !(pop && (occ == PW'(1)));
`else
   assign coal = 1'b0;
`endif

   // A full buffer refuses new slots even if the head pops this cycle
   assign in_ready = !full || coal;
   assign accept   = in_valid && in_ready && (in_addr != REG_ZERO);
   assign alloc    = accept && !coal;
   assign merge    = accept && coal;

   // Next-state for pointers and per-entry occupancy
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      vld_d  = vld_q;
      if (pop) begin
         vld_d[head_idx] = 1'b0;
         head_d          = head_q + PW'(1);
      end
      if (alloc) begin
         vld_d[tail_idx] = 1'b1;
         tail_d          = tail_q + PW'(1);
      end
   end

   // Control state; reset discards every queued write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         vld_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         vld_q  <= vld_d;
      end
   end

   // Entry storage; contents are only meaningful where vld_q is set
   always_ff @(posedge clk) begin
      if (alloc) begin
         ent_q[tail_idx] <= '{addr: in_addr, data: in_data};
      end else if (merge) begin
         ent_q[yng_idx].data <= in_data;
      end
   end

   wbb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd1 (
      .ent_i     (ent_q),
      .vld_i     (vld_q),
      .head_i    (head_q),
      .lk_addr_i (lk_addr1),
      .hit_o     (fwd_hit1),
      .data_o    (fwd_data1)
   );

   wbb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd2 (
      .ent_i     (ent_q),
      .vld_i     (vld_q),
      .head_i    (head_q),
      .lk_addr_i (lk_addr2),
      .hit_o     (fwd_hit2),
      .data_o    (fwd_data2)
   );

endmodule

// File: tb/tb_wb_write_buffer.sv
// Scoreboard bench for wb_write_buffer. A queue-based reference model
// predicts every cycle's outputs; accepted writes go into a scoreboard
// queue that an independent monitor pops whenever the DUT writes the RF.
module tb_wb_write_buffer;
   import cpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic          rf_busy = 1'b0;
   logic          rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_wd;
   logic [AW-1:0] lk_addr1 = '0;
   logic [AW-1:0] lk_addr2 = '0;
   logic          fwd_hit1, fwd_hit2;
   logic [DW-1:0] fwd_data1, fwd_data2;
   logic [CW-1:0] count;
   logic          empty, full;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t mq[$];    // reference model contents, oldest first
   ent_t sbq[$];   // expected RF write stream
   int   n_tests = 0;
   int   n_fail  = 0;

   wb_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .rf_busy   (rf_busy),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_wd     (rf_wd),
      .lk_addr1  (lk_addr1),
      .lk_addr2  (lk_addr2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Would an enqueue to a merge into the youngest queued write?
   function automatic bit m_coal(input logic [AW-1:0] a, input bit busy);
`ifdef WB_WRITE_BUFFER_COALESCE_EN
      if (mq.size() == 0) return 1'b0;
      if (mq[mq.size()-1].a != a) return 1'b0;
      if (!busy && mq.size() == 1) return 1'b0;
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic m_fwd(input logic [AW-1:0] lk, output bit hit, output logic [DW-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (lk != 0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == lk) begin
               hit = 1'b1;
               d   = mq[i].d;
               break;
            end
         end
      end
   endtask

   // One clock of stimulus: called just after a rising edge
   task automatic step(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit busy, input logic [AW-1:0] l1, input logic [AW-1:0] l2);
      bit            e_coal, e_ready, e_we, h1, h2;
      logic [DW-1:0] d1, d2;
      ent_t          e;
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      rf_busy  = busy;
      lk_addr1 = l1;
      lk_addr2 = l2;
      e_coal   = m_coal(a, busy);
      e_ready  = (mq.size() < DEPTH) || e_coal;
      e_we     = (mq.size() > 0) && !busy;
      m_fwd(l1, h1, d1);
      m_fwd(l2, h2, d2);
      @(negedge clk);
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("rf_we", 32'(rf_we), 32'(e_we));
      chk("rf_addr", 32'(rf_addr), mq.size() > 0 ? 32'(mq[0].a) : 32'd0);
      chk("rf_wd", rf_wd, mq.size() > 0 ? mq[0].d : 32'd0);
      chk("fwd_hit1", 32'(fwd_hit1), 32'(h1));
      chk("fwd_data1", fwd_data1, d1);
      chk("fwd_hit2", 32'(fwd_hit2), 32'(h2));
      chk("fwd_data2", fwd_data2, d2);
      @(posedge clk);
      if (e_we) void'(mq.pop_front());
      if (v && e_ready && a != 0) begin
         if (e_coal) begin
            mq[mq.size()-1].d = d;
            if (sbq.size() > 0) sbq[sbq.size()-1].d = d;
         end else begin
            e.a = a;
            e.d = d;
            mq.push_back(e);
            sbq.push_back(e);
         end
      end
      #1;
   endtask

   task automatic idle(input bit busy);
      step(1'b0, '0, '0, busy, '0, '0);
   endtask

   // Monitor: every RF write must be the next expected one, in order
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (rst && rf_we) begin
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rf_unexpected_write: got addr %0h data %0h expected no write", rf_addr, rf_wd);
            end else begin
               e = sbq.pop_front();
               chk("rf_order_addr", 32'(rf_addr), 32'(e.a));
               chk("rf_order_data", rf_wd, e.d);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b1;
      step(1'b0, '0, '0, 1'b0, 5'd5, '0);
      idle(1'b0);

      // Basic drain
      step(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd3, '0);
      step(1'b0, '0, '0, 1'b0, 5'd3, '0);
      idle(1'b0);

      // Busy hold and fill, then four consecutive drains
      for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(i), 1'b1, AW'(i), 5'd1);
      step(1'b1, 5'd9, 32'h9, 1'b1, 5'd4, 5'd9);
      chk("fill_full", 32'(full), 32'd1);
      for (int i = 0; i < 5; i++) idle(1'b0);

      // Forwarding youngest
      step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, '0);
      step(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, '0);
      step(1'b0, '0, '0, 1'b1, 5'd7, 5'd0);
      chk("fwd_youngest", fwd_data1, 32'h22);
      for (int i = 0; i < 3; i++) idle(1'b0);

      // Zero register is accepted and discarded
      step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, '0);
      idle(1'b0);
      idle(1'b0);

      // Async reset mid-drain
      for (int i = 0; i < 3; i++) step(1'b1, AW'(10 + i), DW'(32'hA0 + i), 1'b1, '0, '0);
      rf_busy = 1'b0;
      #1;
      chk("pre_rst_rf_we", 32'(rf_we), 32'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_rf_we", 32'(rf_we), 32'd0);
      chk("async_rst_count", 32'(count), 32'd0);
      mq.delete();
      sbq.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) idle(1'b0);

`ifdef WB_WRITE_BUFFER_COALESCE_EN
      // Coalesce into a full buffer's youngest entry
      for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(i), 1'b1, '0, '0);
      step(1'b1, 5'd4, 32'h99, 1'b1, 5'd4, '0);
      chk("coal_count", 32'(count), 32'd4);
      chk("coal_fwd", fwd_data1, 32'h99);
      for (int i = 0; i < 5; i++) idle(1'b0);
`endif

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      end
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b0);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
